muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative RV32M multiply/divide controller that time-shares the core's 32-bit combinational ALU instead of owning a multiplier or divider. On `start` it takes over the ALU operand and opcode inputs through `alu_sel`. It runs a 32-step shift-add (multiply) or restoring (divide) loop, issuing one ALU add or sub per cycle. It then returns a 32-bit result with a one-cycle `done` pulse. It sits beside the ALU in the execute stage; the datapath stalls while `busy` is high.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `funct3` in 3: RV32M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`, `op_b` in 32: rs1/rs2 values, sampled with `start`.
- `kill` in 1: pipeline flush; aborts any operation in flight.
- `busy` out 1: operation in flight; the datapath stalls.
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.
- `result` out 32: final value; holds until the next `done`.
- `alu_sel` out 1: 1 means the ALU inputs are driven from `alu_a`/`alu_b`/`alu_op`. Equals `busy`.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_op` out 4: ALU opcode. 0000 add, 0001 sub, 1010 no-op.
- `alu_result` in 32: combinational ALU output, same cycle.

## Operation
- States: IDLE, CALC, NEG, DONE.
  - IDLE→CALC on `start`.
  - IDLE→DONE on `start` with a divide op and `op_b`==0.
  - CALC→NEG after 32 steps for a signed op (only with the macro).
  - CALC→DONE after 32 steps otherwise; NEG→DONE; DONE→IDLE.
- `kill` in any state → IDLE next edge; no `done` is produced. `kill` has priority over `start`.
- `start` while not in IDLE is ignored.
- Carry and borrow are derived from MSBs, because the ALU has no carry out:
  - carry(a+b) = a31&b31 | (a31|b31)&~s31
  - borrow(a−b) = ~a31&b31 | (~a31|b31)&d31
- Multiply step. Registers: `hi` (init 0), `lo` (init multiplier), `mcand`.
  - If `lo[0]`: `alu_op`=add, `alu_a`=`hi`, `alu_b`=`mcand`, then {hi,lo} ← {carry, alu_result, lo}>>1.
  - Else: `alu_op`=no-op, {hi,lo} ← {0,hi,lo}>>1.
- Divide step. Registers: `rem` (init 0), `q` (init dividend), `dvsr`.
  - t = rem[31]; s = {rem[30:0], q[31]}.
  - `alu_op`=sub, `alu_a`=s, `alu_b`=`dvsr`.
  - If t | ~borrow: rem ← alu_result, q ← {q[30:0],1}.
  - Else: rem ← s, q ← {q[30:0],0}.
- Result select:
  - MUL: `lo`.
  - MULH, MULHSU, MULHU: `hi`.
  - DIV, DIVU: `q`.
  - REM, REMU: `rem`.
- Divide by zero: quotient 0xFFFFFFFF; remainder = original `op_a`.
- In IDLE/DONE: `alu_op`=1010, `alu_a`=`alu_b`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `alu_sel`=0, `alu_op`=1010, `alu_a`=`alu_b`=0. State is IDLE and all internal registers are 0.
- Latency is measured from the cycle `start` is high to the cycle `done` is high:
  - 33 cycles for unsigned ops and MUL.
  - 34 cycles for signed ops (macro on).
  - 1 cycle for divide by zero.
- `busy` is high from the cycle after `start` through the `done` cycle inclusive.
- Back-to-back: the earliest next `start` is accepted in the cycle after `done`.
- `rst_n` low mid-operation behaves like `kill`, and additionally clears `result`.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - At start, `op_a`/`op_b` are replaced by their magnitudes when the operand is signed and negative. Signedness: MULH a,b; MULHSU a only; DIV/REM a,b.
  - Magnitudes are formed with a block-local ~x+1; the ALU is not used for this.
  - The result sign is recorded: product = sa^sb; quotient = sa^sb; remainder = sa.
  - NEG is visited for every signed op. If the sign is negative it drives `alu_op`=sub, `alu_a`=0, `alu_b`=selected value.
  - MULH high word: if `lo`==0, `result` = 0−hi via the ALU; else `result` = ~hi with no ALU op.
  - Signed divide by zero: quotient 0xFFFFFFFF, remainder `op_a`.
- `MULDIV_SIGNED_EN` undefined: MULH and MULHSU execute as MULHU, DIV as DIVU, REM as REMU. NEG is never entered.

## Test plan
- MUL 7×6 → `result`=42. `done` 33 cycles after `start`; `busy` high for exactly 33 cycles; `alu_sel`==`busy` throughout.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL → 0x00000001.
  - MULHU → 0xFFFFFFFE.
- DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 0x12345678/0 → 0xFFFFFFFF and REMU → 0x12345678, each with `done` 1 cycle after `start` and no ALU activity (`alu_op` stays 1010).
- Assert `kill` on CALC step 10 → `busy`=0 next cycle and no `done`. A new MUL 3×5 started two cycles later returns 15. A `start` pulsed mid-operation is ignored.
- With `MULDIV_SIGNED_EN`:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - MULH −1×−1 → 0; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
  - Latency 34 cycles.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RV32M multiply/divide controller that borrows the execute-stage
// ALU for one add/sub per cycle. A 32-step shift-add (multiply) or restoring
// (divide) loop produces a result that is presented with a one-cycle done.
//
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   start           request, sampled only while idle
//   funct3          RV32M operation select
//   op_a, op_b      rs1/rs2 values, sampled with start
//   kill            pipeline flush, abandons any operation in flight
//   busy            operation in flight (datapath stall)
//   done            one-cycle pulse, result valid in the same cycle
//   result          final value, held until the next done
//   alu_sel         ALU input mux select, equal to busy
//   alu_a, alu_b    ALU operands driven by this block
//   alu_op          ALU opcode: 0000 add, 0001 sub, 1010 no-op
//   alu_result      combinational ALU output
//
// Build option: define MULDIV_SIGNED_EN to execute MULH/MULHSU/DIV/REM as
// signed operations (magnitude loop plus a NEG fix-up cycle). Without it they
// execute as their unsigned counterparts.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            alu_sel,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOP = 4'b1010;
    localparam int unsigned MSB = XLEN - 1;

    typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;

    state_t          state_q, state_d;
    // hi doubles as the divide remainder, lo as the quotient, opb as
    // multiplicand or divisor.
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            sop_q, sop_d;   // signed op, NEG cycle required
    logic            neg_q, neg_d;   // final result must be negated

    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag, div_s, sel;
    logic            carry, borrow;

    // Low word for MUL/DIV/DIVU, high word (or remainder) otherwise.
    function automatic logic [XLEN-1:0] pick(input logic [2:0] f3,
                                             input logic [XLEN-1:0] h,
                                             input logic [XLEN-1:0] l);
        if (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b101) return l;
        return h;
    endfunction

    always_comb begin
`ifdef MULDIV_SIGNED_EN
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                   (funct3 == 3'b110);
`else
        a_signed = 1'b0;
        b_signed = 1'b0;
`endif
        sa    = a_signed & op_a[MSB];
        sb    = b_signed & op_b[MSB];
        a_mag = sa ? (~op_a + XLEN'(1)) : op_a;
        b_mag = sb ? (~op_b + XLEN'(1)) : op_b;
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sop_d    = sop_q;
        neg_d    = neg_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = ALU_NOP;
        carry    = 1'b0;
        borrow   = 1'b0;
        div_s    = '0;
        sel      = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d  = funct3;
                    cnt_d = '0;
                    sop_d = a_signed;
                    neg_d = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
                    if (funct3[2] && op_b == '0) begin
                        result_d = funct3[1] ? op_a : '1;
                        state_d  = DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = a_mag;
                        opb_d   = b_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (f3_q[2]) begin
                    // Restoring step; hi[MSB] is the 33rd remainder bit.
                    div_s  = {hi_q[MSB-1:0], lo_q[MSB]};
                    alu_op = ALU_SUB;
                    alu_a  = div_s;
                    alu_b  = opb_q;
                    borrow = (~div_s[MSB] & opb_q[MSB]) |
                             ((~div_s[MSB] | opb_q[MSB]) & alu_result[MSB]);
                    if (hi_q[MSB] | ~borrow) begin
                        hi_d = alu_result;
                        lo_d = {lo_q[MSB-1:0], 1'b1};
                    end else begin
                        hi_d = div_s;
                        lo_d = {lo_q[MSB-1:0], 1'b0};
                    end
                end else if (lo_q[0]) begin
                    alu_op = ALU_ADD;
                    alu_a  = hi_q;
                    alu_b  = opb_q;
                    carry  = (hi_q[MSB] & opb_q[MSB]) |
                             ((hi_q[MSB] | opb_q[MSB]) & ~alu_result[MSB]);
                    hi_d   = {carry, alu_result[MSB:1]};
                    lo_d   = {alu_result[0], lo_q[MSB:1]};
                end else begin
                    hi_d = {1'b0, hi_q[MSB:1]};
                    lo_d = {hi_q[0], lo_q[MSB:1]};
                end
                if (cnt_q == 5'd31) begin
                    if (sop_q) begin
                        state_d = NEG;
                    end else begin
                        state_d  = DONE;
                        result_d = pick(f3_q, hi_d, lo_d);
                    end
                end
            end
            NEG: begin
                sel     = pick(f3_q, hi_q, lo_q);
                state_d = DONE;
                if (!neg_q) begin
                    result_d = sel;
                end else if (!f3_q[2] && lo_q != '0) begin
                    // High word of -(hi:lo) is ~hi unless lo borrows nothing.
                    result_d = ~hi_q;
                end else begin
                    alu_op   = ALU_SUB;
                    alu_a    = '0;
                    alu_b    = sel;
                    result_d = alu_result;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (kill) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            f3_q     <= '0;
            sop_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sop_q    <= sop_d;
            neg_q    <= neg_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign alu_sel = busy;
    assign done    = (state_q == DONE);
    assign result  = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed RV32M operations with an exact
// arithmetic reference model, queue scoreboard, latency/busy checks, kill and
// mid-operation reset. Honours MULDIV_SIGNED_EN in the reference model.
module tb_muldiv_sequencer;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif

    logic        clk, rst_n, start, kill;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, result, alu_a, alu_b, alu_result;
    logic        busy, done, alu_sel;
    logic [3:0]  alu_op;

    int unsigned tests = 0;
    int unsigned failed = 0;
    logic [31:0] exp_q[$];
    int unsigned lat_q[$];
    logic [31:0] last_res;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .kill(kill), .busy(busy), .done(done),
        .result(result), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_result(alu_result)
    );

    // Core ALU stand-in.
    assign alu_result = (alu_op == 4'b0000) ? alu_a + alu_b :
                        (alu_op == 4'b0001) ? alu_a - alu_b : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3_in,
                                         input logic [31:0] a, input logic [31:0] b);
        logic [2:0]  f3;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          qa, qb;
        f3 = f3_in;
        if (!SIGNED) begin
            if (f3 == 3'd1 || f3 == 3'd2) f3 = 3'd3;
            if (f3 == 3'd4) f3 = 3'd5;
            if (f3 == 3'd6) f3 = 3'd7;
        end
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return qa / qb;
            end
            3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return qa % qb;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [2:0] f3, input logic [31:0] b);
        if (f3[2] && b == 32'h0) return 1;
        if (SIGNED && (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6)) return 34;
        return 33;
    endfunction

    // Called at a negedge; returns at the negedge after done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        int unsigned cyc, busy_cnt, sel_bad;
        logic [31:0] exp_r;
        int unsigned exp_l;
        bit got;
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        exp_q.push_back(model(f3, a, b));
        lat_q.push_back(model_lat(f3, b));
        cyc = 0; busy_cnt = 0; sel_bad = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = inject && (cyc == 5);
            if (inject && cyc == 5) begin
                funct3 = 3'b000; op_a = 32'h1; op_b = 32'h1;
            end
            if (busy === 1'b1) busy_cnt++;
            if (alu_sel !== busy) sel_bad++;
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        exp_r = exp_q.pop_front();
        exp_l = lat_q.pop_front();
        chk("latency", cyc, exp_l);
        chk("busy_cycles", busy_cnt, exp_l);
        chk("alu_sel_eq_busy", sel_bad, 32'h0);
        chk("result", result, exp_r);
        chk("done_alu_op_nop", {28'h0, alu_op}, 32'hA);
        @(negedge clk);
        chk("after_done_idle", {30'h0, busy, done}, 32'h0);
        chk("result_hold", result, exp_r);
        last_res = exp_r;
    endtask

    initial begin
        int unsigned dcnt;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = 3'b000; op_a = 32'h0; op_b = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_alu_sel", {31'h0, alu_sel}, 32'h0);
        chk("rst_alu_op", {28'h0, alu_op}, 32'hA);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'b000, 32'd7, 32'd6, 1'b0);                    // MUL 42
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);      // MUL 1
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);      // MULHU
        run_op(3'b101, 32'd100, 32'd7, 1'b1);                  // DIVU, stray start
        run_op(3'b111, 32'd100, 32'd7, 1'b0);                  // REMU
        run_op(3'b101, 32'h12345678, 32'h0, 1'b0);             // DIVU by zero
        run_op(3'b111, 32'h12345678, 32'h0, 1'b0);             // REMU by zero

        // Kill during CALC.
        funct3 = 3'b000; op_a = 32'hFFFFFFFF; op_b = 32'h00012345; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'h0, busy}, 32'h0);
        chk("kill_result_hold", result, last_res);
        dcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("kill_no_done", dcnt, 32'h0);
        run_op(3'b000, 32'd3, 32'd5, 1'b0);                    // MUL 15

        // Kill wins over start in IDLE.
        start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("kill_over_start", {31'h0, busy}, 32'h0);

        // Signed cases (unsigned behaviour without the build option).
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_op(3'b001, 32'hFFFFFFFD, 32'd5, 1'b0);
        run_op(3'b001, 32'h80000000, 32'd2, 1'b0);
        run_op(3'b100, 32'hFFFFFFF9, 32'h0, 1'b0);
        run_op(3'b110, 32'hFFFFFFF9, 32'h0, 1'b0);

        for (int i = 0; i < 8; i++)
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);

        // Reset mid-operation.
        funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_alu_op", {28'h0, alu_op}, 32'hA);
        run_op(3'b000, 32'd9, 32'd9, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
